// File: rtl/hs_tx_ctrl.sv
// Framing controller feeding a 10-bit LSB-first shift register: one-entry holding
// register on a valid/ready handshake, back-to-back symbols, IDLE_WORD on underrun.
module hs_tx_ctrl #(
  parameter int unsigned BIT_DIV   = 1,
  parameter logic [9:0]  IDLE_WORD = 10'b1101010100
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_en,
  input  logic       in_valid,
  input  logic [9:0] in_data,
  output logic       in_ready,
  output logic [9:0] parallel_out,
  output logic       load_enable,
  output logic       shift_enable,
  output logic       busy,
  output logic       underrun,
  output logic       word_done
);

  typedef enum logic [1:0] {StIdle, StLoad, StShift} state_e;

  localparam logic [3:0] DivMax = 4'(BIT_DIV - 1);

  state_e     state_q, state_d;
  logic       hold_full_q, hold_full_d;
  logic [9:0] hold_data_q, hold_data_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] div_cnt_q, div_cnt_d;
  logic [9:0] pout_q, pout_d;

  logic       accept;
  logic       bit_tick;
  logic       last_bit;
  logic [9:0] load_word;

  // Output decode uses only registered state, so no in_* reaches the hs_sr controls.
  always_comb begin
    in_ready     = !hold_full_q || (state_q == StLoad);
    accept       = in_valid && in_ready;
    bit_tick     = (state_q == StShift) && (div_cnt_q == DivMax);
    last_bit     = bit_tick && (bit_cnt_q == 4'd9);
    load_word    = hold_full_q ? hold_data_q : IDLE_WORD;
    load_enable  = (state_q == StLoad);
    shift_enable = bit_tick;
    word_done    = last_bit;
    underrun     = (state_q == StLoad) && !hold_full_q;
    busy         = (state_q != StIdle);
    parallel_out = (state_q == StLoad) ? load_word : pout_q;
  end

  always_comb begin
    state_d     = state_q;
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    bit_cnt_d   = bit_cnt_q;
    div_cnt_d   = div_cnt_q;
    pout_d      = pout_q;

    // A word accepted during LOAD refills the slot being consumed this cycle.
    if (accept) begin
      hold_full_d = 1'b1;
      hold_data_d = in_data;
    end else if (state_q == StLoad) begin
      hold_full_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (tx_en) state_d = StLoad;
      end
      StLoad: begin
        pout_d    = load_word;
        bit_cnt_d = 4'd0;
        div_cnt_d = 4'd0;
        state_d   = StShift;
      end
      StShift: begin
        if (bit_tick) begin
          div_cnt_d = 4'd0;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (last_bit) state_d = tx_en ? StLoad : StIdle;
        end else begin
          div_cnt_d = div_cnt_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q     <= StIdle;
      hold_full_q <= 1'b0;
      hold_data_q <= 10'd0;
      bit_cnt_q   <= 4'd0;
      div_cnt_q   <= 4'd0;
      pout_q      <= 10'd0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      bit_cnt_q   <= bit_cnt_d;
      div_cnt_q   <= div_cnt_d;
      pout_q      <= pout_d;
    end
  end

endmodule

// File: tb/tb_hs_tx_ctrl.sv
// Directed bench for hs_tx_ctrl: one instance with BIT_DIV=1 and one with BIT_DIV=3
// share the stimulus; each phase checks the instance it targets.
module tb_hs_tx_ctrl;

  localparam logic [9:0] IdleWord = 10'b1101010100;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       tx_en;
  logic       in_valid;
  logic [9:0] in_data;

  logic       rdy1, ld1, sh1, busy1, und1, wd1;
  logic [9:0] pout1;
  logic       rdy3, ld3, sh3, busy3, und3, wd3;
  logic [9:0] pout3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hs_tx_ctrl #(.BIT_DIV(1)) u_dut1 (
    .clk          (clk),
    .n_rst        (n_rst),
    .tx_en        (tx_en),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (rdy1),
    .parallel_out (pout1),
    .load_enable  (ld1),
    .shift_enable (sh1),
    .busy         (busy1),
    .underrun     (und1),
    .word_done    (wd1)
  );

  hs_tx_ctrl #(.BIT_DIV(3)) u_dut3 (
    .clk          (clk),
    .n_rst        (n_rst),
    .tx_en        (tx_en),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (rdy3),
    .parallel_out (pout3),
    .load_enable  (ld3),
    .shift_enable (sh3),
    .busy         (busy3),
    .underrun     (und3),
    .word_done    (wd3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    n_rst    = 1'b1;
    tx_en    = 1'b0;
    in_valid = 1'b0;
    in_data  = 10'd0;
    step();
    step();
    n_rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nload, nx, nsh, nld;
    logic xfer, wd_seen;

    // Test 1: BIT_DIV=1, pre-loaded symbol
    reset_all();
    check("rst_ld", 32'(ld1), 32'd0);
    check("rst_sh", 32'(sh1), 32'd0);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_und", 32'(und1), 32'd0);
    check("rst_wd", 32'(wd1), 32'd0);
    check("rst_pout", 32'(pout1), 32'd0);
    check("rst_rdy", 32'(rdy1), 32'd1);

    in_valid = 1'b1;
    in_data  = 10'h2A5;
    step();
    in_valid = 1'b0;
    check("t1_held_rdy", 32'(rdy1), 32'd0);
    check("t1_idle_busy", 32'(busy1), 32'd0);
    tx_en = 1'b1;
    step();
    check("t1_ld", 32'(ld1), 32'd1);
    check("t1_pout", 32'(pout1), 32'h2A5);
    check("t1_und", 32'(und1), 32'd0);
    check("t1_sh_in_load", 32'(sh1), 32'd0);
    check("t1_busy", 32'(busy1), 32'd1);
    for (int i = 0; i < 10; i++) begin
      step();
      check("t1_sh", 32'(sh1), 32'd1);
      check("t1_no_ld", 32'(ld1), 32'd0);
      check("t1_wd", 32'(wd1), 32'(i == 9));
    end
    step();
    check("t1_next_ld", 32'(ld1), 32'd1);

    // Test 2: underrun words recur every 11 cycles
    check("t2_und", 32'(und1), 32'd1);
    check("t2_pout", 32'(pout1), 32'(IdleWord));
    for (int w = 0; w < 2; w++) begin
      for (int j = 0; j < 10; j++) begin
        step();
        check("t2_gap_ld", 32'(ld1), 32'd0);
      end
      step();
      check("t2_ld", 32'(ld1), 32'd1);
      check("t2_und_rep", 32'(und1), 32'd1);
      check("t2_pout_rep", 32'(pout1), 32'(IdleWord));
    end

    // Test 3: BIT_DIV=3, two back-to-back words
    reset_all();
    in_valid = 1'b1;
    in_data  = 10'h3FF;
    step();
    in_data = 10'h001;
    check("t3_full_rdy", 32'(rdy3), 32'd0);
    tx_en = 1'b1;
    step();
    check("t3_ld", 32'(ld3), 32'd1);
    check("t3_pout", 32'(pout3), 32'h3FF);
    check("t3_und", 32'(und3), 32'd0);
    check("t3_load_rdy", 32'(rdy3), 32'd1);
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 30; c++) begin
      check("t3_sh", 32'(sh3), 32'((c % 3) == 2));
      check("t3_wd", 32'(wd3), 32'(c == 29));
      check("t3_held_rdy", 32'(rdy3), 32'd0);
      check("t3_pout_hold", 32'(pout3), 32'h3FF);
      check("t3_no_ld", 32'(ld3), 32'd0);
      step();
    end
    check("t3_ld2", 32'(ld3), 32'd1);
    check("t3_pout2", 32'(pout3), 32'h001);
    check("t3_und2", 32'(und3), 32'd0);
    check("t3_rdy2", 32'(rdy3), 32'd1);

    // Test 4: continuous valid, one transfer per word, order preserved
    reset_all();
    in_valid = 1'b1;
    in_data  = 10'h100;
    tx_en    = 1'b1;
    nload    = 0;
    nx       = 0;
    for (int k = 1; k <= 130; k++) begin
      xfer = in_valid & rdy3;
      step();
      if (xfer) begin
        nx++;
        in_data = in_data + 10'd1;
      end
      if (ld3) begin
        check("t4_order", 32'(pout3), 32'h100 + 32'(nload));
        check("t4_und", 32'(und3), 32'd0);
        nload++;
      end
      check("t4_ld_sh_excl", 32'(ld3 & sh3), 32'd0);
    end
    check("t4_loads", 32'(nload), 32'd5);
    check("t4_xfers", 32'(nx), 32'd6);

    // Test 5: tx_en cleared at bit 4 still finishes the word
    reset_all();
    tx_en = 1'b1;
    step();
    check("t5_ld", 32'(ld3), 32'd1);
    nsh     = 0;
    wd_seen = 1'b0;
    for (int i = 0; i < 40 && !wd_seen; i++) begin
      step();
      if (sh3) nsh++;
      if (nsh == 4) tx_en = 1'b0;
      if (wd3) wd_seen = 1'b1;
    end
    check("t5_wd_seen", 32'(wd_seen), 32'd1);
    check("t5_shifts", 32'(nsh), 32'd10);
    step();
    check("t5_busy", 32'(busy3), 32'd0);
    check("t5_no_ld", 32'(ld3), 32'd0);
    nld = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ld3) nld++;
    end
    check("t5_idle_loads", 32'(nld), 32'd0);

    // Test 6: reset mid-word discards the held symbol
    reset_all();
    in_valid = 1'b1;
    in_data  = 10'h155;
    tx_en    = 1'b1;
    step();
    check("t6_ld", 32'(pout3), 32'h155);
    in_data = 10'h0AA;
    step();
    in_valid = 1'b0;
    nsh = 0;
    for (int i = 0; i < 40 && nsh < 5; i++) begin
      if (sh3) nsh++;
      if (nsh < 5) step();
    end
    check("t6_reach_bit5", 32'(nsh), 32'd5);
    check("t6_held_rdy", 32'(rdy3), 32'd0);
    n_rst = 1'b1;
    step();
    check("t6_rst_ld", 32'(ld3), 32'd0);
    check("t6_rst_sh", 32'(sh3), 32'd0);
    check("t6_rst_busy", 32'(busy3), 32'd0);
    check("t6_rst_und", 32'(und3), 32'd0);
    check("t6_rst_wd", 32'(wd3), 32'd0);
    check("t6_rst_pout", 32'(pout3), 32'd0);
    check("t6_rst_rdy", 32'(rdy3), 32'd1);
    n_rst = 1'b0;
    step();
    check("t6_re_ld", 32'(ld3), 32'd1);
    check("t6_re_und", 32'(und3), 32'd1);
    check("t6_re_pout", 32'(pout3), 32'(IdleWord));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hs_tx_ctrl.md
Name: hs_tx_ctrl

Overview:
Framing controller directly upstream of the 10-bit LSB-first shift register (hs_sr). Accepts 10-bit symbols over a valid/ready handshake into a one-entry holding register. Drives the shift register's parallel_in, load_enable and shift_enable so the link streams symbols back-to-back, inserting IDLE_WORD whenever no symbol is available.

Parameters:
BIT_DIV, 1, clk cycles per serial bit; legal range 1..16.
IDLE_WORD, 10'b1101010100, filler symbol sent on underrun.

Ports:
clk  input  1  system clock, all logic on rising edge
n_rst  input  1  synchronous, active-high reset (1 = reset)
tx_en  input  1  transmit enable; level-sensitive
in_valid  input  1  upstream symbol valid
in_data  input  10  upstream symbol, bit 0 sent first
in_ready  output  1  holding register can accept this cycle
parallel_out  output  10  to hs_sr parallel_in
load_enable  output  1  to hs_sr load_enable
shift_enable  output  1  to hs_sr shift_enable
busy  output  1  FSM not in IDLE
underrun  output  1  one-cycle pulse, IDLE_WORD loaded
word_done  output  1  one-cycle pulse, coincident with 10th shift pulse

Behaviour:
- Reset (n_rst=1 at a clk edge): state=IDLE, holding register empty, bit_cnt=0, div_cnt=0. All outputs 0 except in_ready, which is 1 from the first cycle after reset.
- Reset mid-word aborts the word. No further shift pulses occur, and the held symbol is discarded.
- Handshake: a transfer occurs on the edge where in_valid & in_ready are both 1. in_ready = !hold_full | (state==LOAD). A word accepted during LOAD overwrites the slot being consumed in that same cycle. in_data must not change while in_valid=1 & in_ready=0; the bench enforces this.
- FSM state IDLE: load_enable=0, shift_enable=0. If tx_en=1, the next state is LOAD. The holding register still accepts one symbol while IDLE.
- FSM state LOAD (exactly 1 cycle): load_enable=1, shift_enable=0.
  - parallel_out = hold_full ? hold_data : IDLE_WORD.
  - If the holding register was empty, underrun=1 this cycle.
  - The holding register is marked empty unless a new word is accepted in the same cycle.
  - Next state is SHIFT; bit_cnt=0 and div_cnt=0.
- FSM state SHIFT:
  - div_cnt counts 0..BIT_DIV-1. shift_enable=1 only in cycles where div_cnt==BIT_DIV-1, and bit_cnt increments on those cycles.
  - For BIT_DIV=1, shift_enable stays high for 10 consecutive cycles.
  - The 10th shift pulse is the cycle with bit_cnt==9 and div_cnt==BIT_DIV-1. In that cycle word_done=1, and the next state is LOAD if tx_en=1, else IDLE.
- load_enable and shift_enable are never both 1 in any cycle. This is required because hs_sr gives shift priority over load.
- parallel_out holds its last loaded value outside LOAD cycles.
- Word period = 1 + 10*BIT_DIV cycles, with no gap between words while tx_en=1.
- tx_en dropping mid-word does not truncate the word. It is sampled only at the 10th shift pulse and in IDLE.
- busy = (state != IDLE).
- Registered outputs: load_enable, shift_enable, parallel_out, underrun and word_done are decoded from registered state and counters. There are no combinational paths from in_* to these outputs. in_ready depends only on registered state.

Test Plan:
1. BIT_DIV=1: reset, then tx_en=1 with 10'h2A5 pre-loaded in IDLE -> LOAD cycle has parallel_out=10'h2A5 and underrun=0. Then 10 consecutive shift_enable cycles follow, word_done=1 on the 10th, and the next cycle is LOAD.
2. BIT_DIV=1, tx_en=1, in_valid=0 throughout -> every LOAD has parallel_out=10'b1101010100 and underrun=1. LOAD cycles recur every 11 cycles.
3. BIT_DIV=3: send 10'h3FF then 10'h001 back-to-back -> shift_enable pulses every 3rd cycle, word period 31 cycles. Second LOAD has parallel_out=10'h001 with no underrun. in_ready=0 while the second word is held during the first word, and in_ready=1 in its LOAD cycle.
4. Backpressure: hold in_valid=1 continuously with incrementing data -> exactly one transfer per word period. No symbol is dropped or duplicated, and the captured serial stream matches the input order.
5. Clear tx_en at bit 4 of a word -> remaining 6 shift pulses complete, word_done fires, then busy=0 and no further load_enable.
6. Assert n_rst at bit 5 with a symbol held -> the next cycle has all outputs 0 and in_ready=1. After re-enable, the first LOAD uses IDLE_WORD with underrun=1, since the held symbol was discarded.
